// File: rtl/lsu_if.sv
// rtl/lsu_if.sv - LSU core-side request/response and memory-side bus bundle
//
// Core side : start, is_store, funct3, Addr, WData -> RData, busy, done, fault
// Memory    : mem_req, mem_we, mem_addr, mem_wdata, mem_be -> mem_rdata, mem_ack
// slave modport is the LSU, master modport is whoever drives it.
interface lsu_if;
  logic        start;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] Addr;
  logic [31:0] WData;
  logic [31:0] RData;
  logic        busy;
  logic        done;
  logic [1:0]  fault;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport slave (
    input  start, is_store, funct3, Addr, WData, mem_rdata, mem_ack,
    output RData, busy, done, fault, mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );

  modport master (
    output start, is_store, funct3, Addr, WData, mem_rdata, mem_ack,
    input  RData, busy, done, fault, mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/lsu.sv
// rtl/lsu.sv - load/store unit: one word-bus access per request, byte/half lane handling
//
// Ports: clk, rst_n (synchronous, active-low), bus (lsu_if.slave).
// Parameter TIMEOUT: number of REQ cycles to wait for mem_ack (2..255).
// Optional macro LSU_MISALIGN_CHECK_EN: reject misaligned H/W accesses with fault 01.
// fault codes: 00 ok, 01 misaligned, 10 timeout, 11 illegal funct3.
module lsu #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  lsu_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_DONE = 2'd2} state_t;

  localparam logic [7:0] LP_CNT_LAST = 8'(TIMEOUT - 1);

  state_t      r_state, w_state_n;
  logic [7:0]  r_cnt;
  logic        r_store;
  logic [2:0]  r_f3;
  logic [1:0]  r_off;
  logic [31:0] r_rdata, r_mem_addr, r_mem_wdata;
  logic [3:0]  r_mem_be;
  logic        r_mem_req, r_mem_we, r_busy, r_done;
  logic [1:0]  r_fault;

  logic        w_illegal, w_misalign;
  logic [1:0]  w_fault_n;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [1:0]  w_lane_off;
  logic [31:0] w_lane, w_ld_data;

  // Stores only have B/H/W; loads additionally have BU/HU.
  always_comb begin
    if (bus.is_store) w_illegal = bus.funct3[2] || (bus.funct3[1:0] == 2'b11);
    else              w_illegal = (bus.funct3 == 3'b011) || (bus.funct3[2:1] == 2'b11);
  end

`ifdef LSU_MISALIGN_CHECK_EN
  assign w_misalign = ((bus.funct3[1:0] == 2'b01) && bus.Addr[0]) ||
                      ((bus.funct3[1:0] == 2'b10) && (bus.Addr[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  // Byte enables and lane-replicated store data, formed from the request inputs.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = bus.WData;
    case (bus.funct3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << bus.Addr[1:0];
        w_wdata = {4{bus.WData[7:0]}};
      end
      2'b01: begin
        w_be    = 4'b0011 << {bus.Addr[1], 1'b0};
        w_wdata = {2{bus.WData[15:0]}};
      end
      default: ;
    endcase
  end

  // Load lane select: halves ignore Addr[0], words always use lane 0.
  always_comb begin
    case (r_f3[1:0])
      2'b00:   w_lane_off = r_off;
      2'b01:   w_lane_off = {r_off[1], 1'b0};
      default: w_lane_off = 2'b00;
    endcase
    w_lane = bus.mem_rdata >> {w_lane_off, 3'b000};
    case (r_f3)
      3'b000:  w_ld_data = {{24{w_lane[7]}}, w_lane[7:0]};
      3'b100:  w_ld_data = {24'd0, w_lane[7:0]};
      3'b001:  w_ld_data = {{16{w_lane[15]}}, w_lane[15:0]};
      3'b101:  w_ld_data = {16'd0, w_lane[15:0]};
      default: w_ld_data = w_lane;
    endcase
  end

  always_comb begin
    w_state_n = r_state;
    w_fault_n = 2'b00;
    case (r_state)
      S_IDLE: if (bus.start) begin
        if (w_illegal) begin
          w_state_n = S_DONE;
          w_fault_n = 2'b11;
        end else if (w_misalign) begin
          w_state_n = S_DONE;
          w_fault_n = 2'b01;
        end else begin
          w_state_n = S_REQ;
        end
      end
      // ack is checked first so an ack in the last allowed cycle still succeeds
      S_REQ: if (bus.mem_ack) begin
        w_state_n = S_DONE;
      end else if (r_cnt == LP_CNT_LAST) begin
        w_state_n = S_DONE;
        w_fault_n = 2'b10;
      end
      S_DONE:  w_state_n = S_IDLE;
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_n;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt       <= 8'd0;
      r_store     <= 1'b0;
      r_f3        <= 3'd0;
      r_off       <= 2'd0;
      r_rdata     <= 32'd0;
      r_mem_addr  <= 32'd0;
      r_mem_wdata <= 32'd0;
      r_mem_be    <= 4'd0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_fault     <= 2'd0;
    end else begin
      r_busy    <= (w_state_n != S_IDLE);
      r_done    <= (w_state_n == S_DONE);
      r_fault   <= w_fault_n;
      r_mem_req <= (w_state_n == S_REQ);
      if (r_state == S_IDLE && bus.start) begin
        r_store <= bus.is_store;
        r_f3    <= bus.funct3;
        r_off   <= bus.Addr[1:0];
        r_cnt   <= 8'd0;
        if (w_state_n == S_REQ) begin
          r_mem_addr  <= {bus.Addr[31:2], 2'b00};
          r_mem_be    <= w_be;
          r_mem_wdata <= w_wdata;
          r_mem_we    <= bus.is_store;
        end
      end
      if (r_state == S_REQ) begin
        if (w_state_n != S_REQ) r_mem_we <= 1'b0;
        else                    r_cnt    <= r_cnt + 8'd1;
        if (bus.mem_ack && !r_store) r_rdata <= w_ld_data;
      end
    end
  end

  assign bus.RData     = r_rdata;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.fault     = r_fault;
  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_be    = r_mem_be;
endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - scoreboard bench for lsu
module tb_lsu;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  lsu_if bus();
  lsu #(.TIMEOUT(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  fault;
    int          done_cyc;
    int          req_cycles;
  } exp_t;
  exp_t sb[$];

  logic [31:0] model_rdata;
  int          o_done_cyc, o_req_cycles;
  logic [31:0] o_rdata, o_maddr, o_wd;
  logic [1:0]  o_fault;
  logic [3:0]  o_be;
  logic        o_we;

  // Issue one access at a negedge in IDLE; cycle 0 is the start cycle.
  // ack_at = cycle in which mem_ack is high (0 = never). Returns one cycle after done.
  task automatic access(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rd, input int ack_at);
    bus.start = 1'b1; bus.is_store = st; bus.funct3 = f3; bus.Addr = a; bus.WData = wd;
    o_done_cyc = -1; o_req_cycles = 0; o_rdata = 'x; o_fault = 'x;
    o_maddr = 'x; o_be = 'x; o_wd = 'x; o_we = 'x;
    for (int c = 1; c <= 40 && o_done_cyc < 0; c++) begin
      @(posedge clk); @(negedge clk);
      bus.start = 1'b0;
      bus.mem_ack = 1'b0;
      if (bus.done) begin
        o_done_cyc = c; o_rdata = bus.RData; o_fault = bus.fault;
      end
      if (bus.mem_req) begin
        if (o_req_cycles == 0) begin
          o_maddr = bus.mem_addr; o_be = bus.mem_be; o_wd = bus.mem_wdata; o_we = bus.mem_we;
        end
        o_req_cycles++;
      end
      if (c == ack_at) begin
        bus.mem_ack = 1'b1; bus.mem_rdata = rd;
      end
    end
    bus.mem_ack = 1'b0;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 0; bus.is_store = 0; bus.funct3 = 0; bus.Addr = 0; bus.WData = 0;
    bus.mem_rdata = 0; bus.mem_ack = 0;
    repeat (3) @(negedge clk);
    checks++; if ({bus.busy, bus.done, bus.fault, bus.mem_req, bus.mem_we} !== 6'd0) begin
      failures++; $display("FAIL reset_ctrl got=%b exp=000000", {bus.busy, bus.done, bus.fault, bus.mem_req, bus.mem_we});
    end
    checks++; if ({bus.RData, bus.mem_addr, bus.mem_wdata, bus.mem_be} !== 100'd0) begin
      failures++; $display("FAIL reset_data got=%h/%h/%h/%b exp=0", bus.RData, bus.mem_addr, bus.mem_wdata, bus.mem_be);
    end
    rst_n = 1'b1;
    model_rdata = 32'd0;
    @(negedge clk);
  endtask

  task automatic test_lb();
    exp_t e;
    sb.push_back('{32'hFFFF_FF80, 2'b00, 2, 1});
    access(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_1234, 1);
    e = sb.pop_front(); model_rdata = e.rdata;
    checks++; if (o_rdata !== e.rdata) begin failures++; $display("FAIL lb_rdata got=%h exp=%h", o_rdata, e.rdata); end
    checks++; if (o_fault !== e.fault) begin failures++; $display("FAIL lb_fault got=%b exp=%b", o_fault, e.fault); end
    checks++; if (o_done_cyc !== e.done_cyc) begin failures++; $display("FAIL lb_done_cyc got=%0d exp=%0d", o_done_cyc, e.done_cyc); end
    checks++; if (o_req_cycles !== e.req_cycles) begin failures++; $display("FAIL lb_req_cycles got=%0d exp=%0d", o_req_cycles, e.req_cycles); end
    checks++; if ({o_maddr, o_be, o_we} !== {32'h100, 4'b1000, 1'b0}) begin
      failures++; $display("FAIL lb_bus got=%h/%b/%b exp=00000100/1000/0", o_maddr, o_be, o_we);
    end
  endtask

  task automatic test_sh();
    exp_t e;
    sb.push_back('{model_rdata, 2'b00, 2, 1});
    access(1'b1, 3'b001, 32'h202, 32'h0000_BEEF, 32'h5555_5555, 1);
    e = sb.pop_front();
    checks++; if ({o_maddr, o_be, o_wd, o_we} !== {32'h200, 4'b1100, 32'hBEEF_BEEF, 1'b1}) begin
      failures++; $display("FAIL sh_bus got=%h/%b/%h/%b exp=00000200/1100/beefbeef/1", o_maddr, o_be, o_wd, o_we);
    end
    checks++; if (o_rdata !== e.rdata) begin failures++; $display("FAIL sh_rdata_kept got=%h exp=%h", o_rdata, e.rdata); end
    checks++; if ({o_fault, o_done_cyc} !== {e.fault, e.done_cyc}) begin
      failures++; $display("FAIL sh_done got=%b@%0d exp=%b@%0d", o_fault, o_done_cyc, e.fault, e.done_cyc);
    end
  endtask

  task automatic test_lhu_wait();
    exp_t e;
    sb.push_back('{32'h0000_F00D, 2'b00, 4, 3});
    access(1'b0, 3'b101, 32'h10, 32'h0, 32'h0000_F00D, 3);
    e = sb.pop_front(); model_rdata = e.rdata;
    checks++; if (o_rdata !== e.rdata) begin failures++; $display("FAIL lhu_rdata got=%h exp=%h", o_rdata, e.rdata); end
    checks++; if ({o_done_cyc, o_req_cycles} !== {e.done_cyc, e.req_cycles}) begin
      failures++; $display("FAIL lhu_timing got=%0d/%0d exp=%0d/%0d", o_done_cyc, o_req_cycles, e.done_cyc, e.req_cycles);
    end
  endtask

  task automatic test_load_ext();
    logic [2:0]  f3 [5] = '{3'b001, 3'b100, 3'b000, 3'b010, 3'b101};
    logic [31:0] ad [5] = '{32'h12, 32'h1, 32'h0, 32'h20, 32'h2};
    logic [31:0] rd [5] = '{32'h8001_0000, 32'h0000_A500, 32'h0000_007F, 32'hDEAD_BEEF, 32'h89AB_0000};
    logic [31:0] ex [5] = '{32'hFFFF_8001, 32'h0000_00A5, 32'h0000_007F, 32'hDEAD_BEEF, 32'h0000_89AB};
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      sb.push_back('{ex[i], 2'b00, 3, 2});
      access(1'b0, f3[i], ad[i], 32'h0, rd[i], 2);
      e = sb.pop_front(); model_rdata = e.rdata;
      checks++; if ({o_rdata, o_fault, o_done_cyc} !== {e.rdata, e.fault, e.done_cyc}) begin
        failures++; $display("FAIL ld_ext[%0d] got=%h/%b@%0d exp=%h/%b@%0d", i, o_rdata, o_fault, o_done_cyc, e.rdata, e.fault, e.done_cyc);
      end
    end
  endtask

  task automatic test_timeout();
    exp_t e;
    sb.push_back('{model_rdata, 2'b10, 17, 16});
    access(1'b0, 3'b010, 32'h40, 32'h0, 32'h1234_5678, 0);
    e = sb.pop_front();
    checks++; if (o_req_cycles !== e.req_cycles) begin failures++; $display("FAIL to_req_cycles got=%0d exp=%0d", o_req_cycles, e.req_cycles); end
    checks++; if ({o_fault, o_done_cyc} !== {e.fault, e.done_cyc}) begin
      failures++; $display("FAIL to_done got=%b@%0d exp=%b@%0d", o_fault, o_done_cyc, e.fault, e.done_cyc);
    end
    checks++; if (o_rdata !== e.rdata) begin failures++; $display("FAIL to_rdata_kept got=%h exp=%h", o_rdata, e.rdata); end
    // ack in the last allowed REQ cycle still completes cleanly
    sb.push_back('{32'hCAFE_0001, 2'b00, 17, 16});
    access(1'b0, 3'b010, 32'h44, 32'h0, 32'hCAFE_0001, 16);
    e = sb.pop_front(); model_rdata = e.rdata;
    checks++; if ({o_rdata, o_fault, o_done_cyc, o_req_cycles} !== {e.rdata, e.fault, e.done_cyc, e.req_cycles}) begin
      failures++; $display("FAIL to_last_ack got=%h/%b@%0d/%0d exp=%h/%b@%0d/%0d", o_rdata, o_fault, o_done_cyc, o_req_cycles, e.rdata, e.fault, e.done_cyc, e.req_cycles);
    end
  endtask

  task automatic test_misalign();
    exp_t e;
`ifdef LSU_MISALIGN_CHECK_EN
    sb.push_back('{model_rdata, 2'b01, 1, 0});
`else
    sb.push_back('{32'h1122_3344, 2'b00, 2, 1});
`endif
    access(1'b0, 3'b010, 32'h6, 32'h0, 32'h1122_3344, 1);
    e = sb.pop_front(); model_rdata = e.rdata;
    checks++; if ({o_rdata, o_fault, o_done_cyc, o_req_cycles} !== {e.rdata, e.fault, e.done_cyc, e.req_cycles}) begin
      failures++; $display("FAIL mis_lw got=%h/%b@%0d/%0d exp=%h/%b@%0d/%0d", o_rdata, o_fault, o_done_cyc, o_req_cycles, e.rdata, e.fault, e.done_cyc, e.req_cycles);
    end
`ifndef LSU_MISALIGN_CHECK_EN
    checks++; if ({o_maddr, o_be} !== {32'h4, 4'b1111}) begin
      failures++; $display("FAIL mis_lw_bus got=%h/%b exp=00000004/1111", o_maddr, o_be);
    end
`endif
  endtask

  task automatic test_illegal();
    logic        st [2] = '{1'b1, 1'b0};
    logic [2:0]  f3 [2] = '{3'b100, 3'b111};
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      sb.push_back('{model_rdata, 2'b11, 1, 0});
      access(st[i], f3[i], 32'h80, 32'hFFFF_FFFF, 32'h7777_7777, 1);
      e = sb.pop_front();
      checks++; if ({o_rdata, o_fault, o_done_cyc, o_req_cycles} !== {e.rdata, e.fault, e.done_cyc, e.req_cycles}) begin
        failures++; $display("FAIL illegal[%0d] got=%h/%b@%0d/%0d exp=%h/%b@%0d/%0d", i, o_rdata, o_fault, o_done_cyc, o_req_cycles, e.rdata, e.fault, e.done_cyc, e.req_cycles);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    sb.push_back('{model_rdata, 2'b00, 2, 1});
    sb.push_back('{32'h0000_0056, 2'b00, 2, 1});
    access(1'b1, 3'b000, 32'h1, 32'h1234_5678, 32'h0, 1);
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL b2b_busy got=%b exp=0", bus.busy); end
    e = sb.pop_front();
    checks++; if ({o_be, o_wd, o_done_cyc} !== {4'b0010, 32'h7878_7878, e.done_cyc}) begin
      failures++; $display("FAIL b2b_sb got=%b/%h@%0d exp=0010/78787878@%0d", o_be, o_wd, o_done_cyc, e.done_cyc);
    end
    access(1'b0, 3'b100, 32'h2, 32'h0, 32'h1256_3412, 1);
    e = sb.pop_front(); model_rdata = e.rdata;
    checks++; if ({o_rdata, o_done_cyc} !== {e.rdata, e.done_cyc}) begin
      failures++; $display("FAIL b2b_lbu got=%h@%0d exp=%h@%0d", o_rdata, o_done_cyc, e.rdata, e.done_cyc);
    end
  endtask

  task automatic test_reset_in_req();
    int dones = 0;
    bus.start = 1'b1; bus.is_store = 1'b0; bus.funct3 = 3'b010; bus.Addr = 32'h48;
    @(posedge clk); @(negedge clk);
    bus.start = 1'b0;
    checks++; if (bus.mem_req !== 1'b1) begin failures++; $display("FAIL rst_req_pre got=%b exp=1", bus.mem_req); end
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++; if ({bus.mem_req, bus.busy, bus.done} !== 3'b000) begin
      failures++; $display("FAIL rst_req_drop got=%b exp=000", {bus.mem_req, bus.busy, bus.done});
    end
    rst_n = 1'b1;
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'hABCD_EF01;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    bus.mem_ack = 1'b0;
    checks++; if (dones !== 0) begin failures++; $display("FAIL rst_no_done got=%0d exp=0", dones); end
    checks++; if (bus.RData !== 32'd0) begin failures++; $display("FAIL rst_rdata got=%h exp=00000000", bus.RData); end
  endtask

  initial begin
    test_reset();
    test_lb();
    test_sh();
    test_lhu_wait();
    test_load_ext();
    test_timeout();
    test_misalign();
    test_illegal();
    test_back_to_back();
    test_reset_in_req();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
